filter_sample_sequencer: RTL

//   Drives the shared time-multiplexed FIR/IIR/MAF filter engine: generates the sample strobe
//   (flt_en) at a programmable rate, presents the held input sample, waits for the engine's

---
 rtl/filter_sample_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/filter_sample_sequencer.sv
// filter_sample_sequencer
//   Sequences the shared time-multiplexed FIR/IIR/MAF filter engine. A
//   programmable divider produces sample ticks. Each accepted tick latches
//   the input sample, strobes the engine for one cycle and waits SETTLE
//   cycles for the engine's phase sequence to finish. The three results are
//   then captured into a small show-ahead FIFO that a valid/ready consumer
//   drains.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   enable_i        run the sample divider (0 = no new ticks)
//   div_i           sample period minus 1, in clk cycles
//   x_in_i          input sample, latched on an accepted tick
//   flt_en_o        one-cycle strobe to the filter core
//   flt_x_o         held sample presented to the filter core
//   y_fir_i/y_iir_i/y_maf_i   filter core results
//   out_valid_o     FIFO head valid
//   out_ready_i     consumer accepts the head
//   out_fir_o/out_iir_o/out_maf_o  FIFO head results
//   busy_o          a conversion is in flight
//   overrun_o       sticky: a tick or a result was dropped
//   overrun_clr_i   clears overrun_o (a new drop in the same cycle wins)
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for a sample tick
// FIRE    | flt_en strobe to the engine, sample presented
// WAIT    | engine running, counting SETTLE cycles
// CAPTURE | results final, pushed into the FIFO

module filter_sample_sequencer #(
  parameter int N          = 16,
  parameter int DIV_W      = 16,
  parameter int SETTLE     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [N-1:0]     x_in_i,
  output logic             flt_en_o,
  output logic [N-1:0]     flt_x_o,
  input  logic [N-1:0]     y_fir_i,
  input  logic [N-1:0]     y_iir_i,
  input  logic [N-1:0]     y_maf_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     out_fir_o,
  output logic [N-1:0]     out_iir_o,
  output logic [N-1:0]     out_maf_o,
  output logic             busy_o,
  output logic             overrun_o,
  input  logic             overrun_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  // ---------------------------------------------------------------------
  // Sample divider
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick = enable_i && (cnt_q == div_i);

  // A div lowered below the running count is not caught until the count
  // wraps through zero.
  always_comb begin
    cnt_d = '0;
    if (enable_i) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------
  state_t        state_q;
  logic [WW-1:0] wcnt_q;
  logic          flt_en_q;
  logic [N-1:0]  flt_x_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      flt_en_q <= 1'b0;
      flt_x_q  <= '0;
    end else begin
      flt_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q  <= S_FIRE;
            flt_en_q <= 1'b1;
            flt_x_q  <= x_in_i;
          end
        end
        S_FIRE: begin
          state_q <= S_WAIT;
          wcnt_q  <= WW'(SETTLE - 1);
        end
        S_WAIT: begin
          if (wcnt_q == '0) state_q <= S_CAPTURE;
          else              wcnt_q  <= wcnt_q - WW'(1);
        end
        S_CAPTURE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign flt_en_o = flt_en_q;
  assign flt_x_o  = flt_x_q;
  assign busy_o   = (state_q != S_IDLE);

  // ---------------------------------------------------------------------
  // Result FIFO (show-ahead, pointers carry one wrap bit)
  // ---------------------------------------------------------------------
  logic [3*N-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           empty, full, push, pop, push_ok, push_drop, tick_drop;
  logic [3*N-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push      = (state_q == S_CAPTURE);
  assign pop       = !empty && out_ready_i;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;
  assign tick_drop = tick && (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {y_fir_i, y_iir_i, y_maf_i};
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid_o = !empty;
  assign out_fir_o   = head[3*N-1:2*N];
  assign out_iir_o   = head[2*N-1:N];
  assign out_maf_o   = head[N-1:0];

  // ---------------------------------------------------------------------
  // Sticky overrun flag
  // ---------------------------------------------------------------------
  logic overrun_q, overrun_d;

  assign overrun_d = (overrun_q && !overrun_clr_i) || tick_drop || push_drop;

  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun_o = overrun_q;

endmodule
